execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the five-stage RV32 pipeline, directly downstream of decode_stage and the ID/EX register.
- Resolves operand forwarding from EX/MEM and MEM/WB, then runs the ALU: single-cycle integer ops and MUL, plus a sequential 32-iteration divider for DIV/DIVU/REM/REMU.
- Owns and drives the EX/MEM pipeline register.
- Raises ex_stall to freeze PC, IF/ID and ID/EX while a divide is in progress.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_ENABLE, 1, 0 removes the divider; div ops then write 0 with no stall.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- IDEX_valid  in  1  ID/EX holds a real instruction; 0 means bubble.
- IDEX_read_data1, IDEX_read_data2  in  32  register file operands.
- IDEX_imm  in  32  sign-extended immediate.
- IDEX_rs1, IDEX_rs2, IDEX_rd  in  5  register indices.
- IDEX_aluOP  in  4  operation code.
- IDEX_AluSrc  in  1  1 selects imm as operand B.
- IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite  in  1  control bits.
- MEMWB_rd  in  5  MEM/WB destination index.
- MEMWB_WriteBack  in  1  MEM/WB write enable.
- MEMWB_data  in  32  MEM/WB writeback value.
- EXMEM_alu_result  out  32  registered ALU result.
- EXMEM_write_data  out  32  registered forwarded rs2 value (store data).
- EXMEM_rd  out  5  registered destination index.
- EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite  out  1  registered control bits.
- ex_stall  out  1  combinational; hold upstream stages this cycle.

Behaviour:
- Reset: all EXMEM_* outputs are 0, the FSM goes to IDLE, the divider counter is 0, ex_stall is 0. A reset mid-divide aborts the divide and no result is written.
- Forwarding for rs1 and rs2 independently:
  - EX/MEM match (own EXMEM_WriteBack, EXMEM_rd == rs, rs != 0) takes priority and forwards EXMEM_alu_result.
  - Otherwise a MEM/WB match (same conditions) forwards MEMWB_data.
  - Otherwise the ID/EX value is used.
  - Index 0 is never forwarded.
- Operand B is IDEX_imm when AluSrc=1, else forwarded rs2. EXMEM_write_data is always the forwarded rs2.
- aluOP codes and results:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL: low 32 bits of the product.
  - 11 LUI-pass: result = B.
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
  - Shifts use B[4:0]. All arithmetic wraps modulo 2^32.
- Single-cycle ops: the EX/MEM register captures the result and controls on the next rising edge. Latency is 1 and ex_stall stays 0.
- Bubble (IDEX_valid=0): EX/MEM captures WriteBack, MemoryRead and MemoryWrite as 0. Data fields are don't-care but are held at 0.
- Divider FSM, states IDLE, DIV_RUN and DIV_DONE:
  - IDLE: when a valid div op (aluOP 12..15) is present, latch the forwarded A and B, the signedness, the rem/quot select and rd. Go to DIV_RUN with count=0 and ex_stall=1.
  - DIV_RUN: one restoring-division step per cycle on the operand magnitudes. At count==31, go to DIV_DONE. ex_stall=1 throughout.
  - DIV_DONE: apply sign fix-up, ex_stall=0, EX/MEM captures the div result at this edge, next state is IDLE.
  - Instruction residency in EX is fixed at 34 cycles; ex_stall is high for 33 consecutive cycles.
  - While ex_stall=1, EX/MEM captures a bubble (all control bits 0).
  - Operands are latched at divider start. Later changes on MEMWB_* and IDEX_* during the divide are ignored.
- Division special cases (RISC-V), with unchanged 34-cycle latency:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV of 0x80000000 by -1: quotient = 0x80000000, remainder = 0.
  - Signed remainder takes the sign of the dividend.
- Back-to-back div ops: the second enters IDLE on the edge after DIV_DONE and starts immediately, with no gap cycle.

Decomposition:
- Shared header/package exec_defs holds the aluOP code constants, the FSM state encodings, and DIV_ITERS=32.
- One sub-module, div_unit_seq, owns the sequential divider: FSM, counter, remainder/quotient registers and sign fix-up. Its handshake is start/busy/done with result.
- Forwarding mux, ALU and the EX/MEM register stay in execute_stage.

Test Plan:
- Reset mid-flow -> every EXMEM_* is 0 and ex_stall=0 on the cycle after the reset edge.
- ADD, rs1=x5 with EX/MEM rd=5=10 and MEM/WB rd=5=20, rs2=3 -> EXMEM_alu_result=13. This proves EX/MEM priority.
- Producer writing rd=x0 with value 99, consumer reads x0 (reg file returns 0) -> operand is 0 and no forwarding occurs.
- DIV -7/2 -> ex_stall high exactly 33 cycles, then result 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF. MEMWB_data toggling during the divide does not alter the result.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0. Every case takes the 34-cycle residency.
- Reset asserted at divide cycle 10 -> FSM returns to IDLE, ex_stall=0, and no writeback occurs. A fresh ADD 1+1 afterwards gives 2.

Source files
------------

// File: rtl/exec_defs_pkg.sv
// Shared definitions for the EX stage: ALU op codes, divider FSM states and
// the EX/MEM register payload.
package exec_defs_pkg;

  localparam int unsigned XLEN_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W-1:0] OP_OR   = 4'd8;
  localparam logic [OP_W-1:0] OP_AND  = 4'd9;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd10;
  localparam logic [OP_W-1:0] OP_LUI  = 4'd11;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd12;
  localparam logic [OP_W-1:0] OP_DIVU = 4'd13;
  localparam logic [OP_W-1:0] OP_REM  = 4'd14;
  localparam logic [OP_W-1:0] OP_REMU = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [XLEN_W-1:0] alu_result;
    logic [XLEN_W-1:0] write_data;
    logic [REG_W-1:0]  rd;
    logic              wb;
    logic              mem_read;
    logic              mem_write;
  } exmem_t;

  // Codes 12..15 are the divide/remainder family.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/div_unit_seq.sv
// Sequential 32-step restoring divider with RISC-V sign fix-up.
// start is accepted only in IDLE; done_c marks the single result cycle.
module div_unit_seq
  import exec_defs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [XLEN_W-1:0] a,
  input  logic [XLEN_W-1:0] b,
  input  logic              is_signed,
  input  logic              sel_rem,
  input  logic [REG_W-1:0]  rd,
  output logic              busy_c,
  output logic              done_c,
  output logic [XLEN_W-1:0] result_c,
  output logic [REG_W-1:0]  rd_q
);

  div_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [XLEN_W-1:0] rem_q, rem_n, quo_q, quo_n, dvs_q, dvs_n;
  logic              neg_q_q, neg_q_n, neg_r_q, neg_r_n, sel_rem_q, sel_rem_n;
  logic [REG_W-1:0]  rd_n;
  logic [XLEN_W:0]   rem_sh;
  logic              ge;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rem_q     <= rem_n;
      quo_q     <= quo_n;
      dvs_q     <= dvs_n;
      neg_q_q   <= neg_q_n;
      neg_r_q   <= neg_r_n;
      sel_rem_q <= sel_rem_n;
      rd_q      <= rd_n;
    end
  end

  // Dividend magnitude is shifted out of quo_q into the partial remainder.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    rem_n     = rem_q;
    quo_n     = quo_q;
    dvs_n     = dvs_q;
    neg_q_n   = neg_q_q;
    neg_r_n   = neg_r_q;
    sel_rem_n = sel_rem_q;
    rd_n      = rd_q;
    rem_sh    = {rem_q, quo_q[XLEN_W-1]};
    ge        = rem_sh >= {1'b0, dvs_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n   = DIV_RUN;
          cnt_n     = '0;
          rem_n     = '0;
          quo_n     = (is_signed && a[XLEN_W-1]) ? -a : a;
          dvs_n     = (is_signed && b[XLEN_W-1]) ? -b : b;
          // Divide-by-zero keeps the all-ones quotient regardless of sign.
          neg_q_n   = is_signed && (a[XLEN_W-1] ^ b[XLEN_W-1]) && (b != '0);
          neg_r_n   = is_signed && a[XLEN_W-1];
          sel_rem_n = sel_rem;
          rd_n      = rd;
        end
      end
      DIV_RUN: begin
        rem_n = ge ? (rem_sh[XLEN_W-1:0] - dvs_q) : rem_sh[XLEN_W-1:0];
        quo_n = {quo_q[XLEN_W-2:0], ge};
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_n = DIV_DONE;
      end
      DIV_DONE: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign busy_c   = (state_q == DIV_RUN);
  assign done_c   = (state_q == DIV_DONE);
  assign result_c = sel_rem_q ? (neg_r_q ? -rem_q : rem_q)
                              : (neg_q_q ? -quo_q : quo_q);

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: operand forwarding, single-cycle ALU/MUL, sequential divider
// and the EX/MEM pipeline register.
module execute_stage
  import exec_defs_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          DIV_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IDEX_valid,
  input  logic [XLEN-1:0] IDEX_read_data1,
  input  logic [XLEN-1:0] IDEX_read_data2,
  input  logic [XLEN-1:0] IDEX_imm,
  input  logic [4:0]      IDEX_rs1,
  input  logic [4:0]      IDEX_rs2,
  input  logic [4:0]      IDEX_rd,
  input  logic [3:0]      IDEX_aluOP,
  input  logic            IDEX_AluSrc,
  input  logic            IDEX_WriteBack,
  input  logic            IDEX_MemoryRead,
  input  logic            IDEX_MemoryWrite,
  input  logic [4:0]      MEMWB_rd,
  input  logic            MEMWB_WriteBack,
  input  logic [XLEN-1:0] MEMWB_data,
  output logic [XLEN-1:0] EXMEM_alu_result,
  output logic [XLEN-1:0] EXMEM_write_data,
  output logic [4:0]      EXMEM_rd,
  output logic            EXMEM_WriteBack,
  output logic            EXMEM_MemoryRead,
  output logic            EXMEM_MemoryWrite,
  output logic            ex_stall
);

  exmem_t            exmem_q, exmem_n;
  logic [XLEN-1:0]   fwd_a, fwd_b, op_b, alu_res;
  logic [4:0]        shamt;
  logic              div_start, div_busy_c, div_done_c;
  logic [XLEN-1:0]   div_result_c;
  logic [REG_W-1:0]  div_rd;

  // EX/MEM beats MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = IDEX_read_data1;
    if (exmem_q.wb && exmem_q.rd == IDEX_rs1 && IDEX_rs1 != '0) fwd_a = exmem_q.alu_result;
    else if (MEMWB_WriteBack && MEMWB_rd == IDEX_rs1 && IDEX_rs1 != '0) fwd_a = MEMWB_data;
    fwd_b = IDEX_read_data2;
    if (exmem_q.wb && exmem_q.rd == IDEX_rs2 && IDEX_rs2 != '0) fwd_b = exmem_q.alu_result;
    else if (MEMWB_WriteBack && MEMWB_rd == IDEX_rs2 && IDEX_rs2 != '0) fwd_b = MEMWB_data;
  end

  assign op_b  = IDEX_AluSrc ? IDEX_imm : fwd_b;
  assign shamt = op_b[4:0];

  // Divide codes fall to 0 here; with the divider present they never reach EX/MEM.
  always_comb begin
    alu_res = '0;
    unique case (IDEX_aluOP)
      OP_ADD:  alu_res = fwd_a + op_b;
      OP_SUB:  alu_res = fwd_a - op_b;
      OP_SLL:  alu_res = fwd_a << shamt;
      OP_SLT:  alu_res = XLEN'($signed(fwd_a) < $signed(op_b));
      OP_SLTU: alu_res = XLEN'(fwd_a < op_b);
      OP_XOR:  alu_res = fwd_a ^ op_b;
      OP_SRL:  alu_res = fwd_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
      OP_OR:   alu_res = fwd_a | op_b;
      OP_AND:  alu_res = fwd_a & op_b;
      OP_MUL:  alu_res = fwd_a * op_b;
      OP_LUI:  alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign div_start = DIV_ENABLE && !reset && IDEX_valid && is_div_op(IDEX_aluOP)
                     && !div_busy_c && !div_done_c;
  assign ex_stall  = div_start || div_busy_c;

  if (DIV_ENABLE) begin : g_div
    div_unit_seq u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .a         (fwd_a),
      .b         (op_b),
      .is_signed (IDEX_aluOP == OP_DIV || IDEX_aluOP == OP_REM),
      .sel_rem   (IDEX_aluOP[1]),
      .rd        (IDEX_rd),
      .busy_c    (div_busy_c),
      .done_c    (div_done_c),
      .result_c  (div_result_c),
      .rd_q      (div_rd)
    );
  end else begin : g_no_div
    assign div_busy_c   = 1'b0;
    assign div_done_c   = 1'b0;
    assign div_result_c = '0;
    assign div_rd       = '0;
  end

  // Stall and bubble cycles both load an all-zero EX/MEM entry.
  always_comb begin
    exmem_n = '0;
    if (div_done_c) begin
      exmem_n.alu_result = div_result_c;
      exmem_n.rd         = div_rd;
      exmem_n.wb         = 1'b1;
    end else if (IDEX_valid && !ex_stall) begin
      exmem_n.alu_result = alu_res;
      exmem_n.write_data = fwd_b;
      exmem_n.rd         = IDEX_rd;
      exmem_n.wb         = IDEX_WriteBack;
      exmem_n.mem_read   = IDEX_MemoryRead;
      exmem_n.mem_write  = IDEX_MemoryWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) exmem_q <= '0;
    else       exmem_q <= exmem_n;
  end

  assign EXMEM_alu_result  = exmem_q.alu_result;
  assign EXMEM_write_data  = exmem_q.write_data;
  assign EXMEM_rd          = exmem_q.rd;
  assign EXMEM_WriteBack   = exmem_q.wb;
  assign EXMEM_MemoryRead  = exmem_q.mem_read;
  assign EXMEM_MemoryWrite = exmem_q.mem_write;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed forwarding/divide cases plus
// randomized ALU traffic against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        IDEX_valid, IDEX_AluSrc, IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite;
  logic [31:0] IDEX_read_data1, IDEX_read_data2, IDEX_imm;
  logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
  logic [3:0]  IDEX_aluOP;
  logic [4:0]  MEMWB_rd;
  logic        MEMWB_WriteBack;
  logic [31:0] MEMWB_data;
  logic [31:0] EXMEM_alu_result, EXMEM_write_data;
  logic [4:0]  EXMEM_rd;
  logic        EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite;
  logic        ex_stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .DIV_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .IDEX_valid(IDEX_valid),
    .IDEX_read_data1(IDEX_read_data1), .IDEX_read_data2(IDEX_read_data2),
    .IDEX_imm(IDEX_imm), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
    .IDEX_aluOP(IDEX_aluOP), .IDEX_AluSrc(IDEX_AluSrc), .IDEX_WriteBack(IDEX_WriteBack),
    .IDEX_MemoryRead(IDEX_MemoryRead), .IDEX_MemoryWrite(IDEX_MemoryWrite),
    .MEMWB_rd(MEMWB_rd), .MEMWB_WriteBack(MEMWB_WriteBack), .MEMWB_data(MEMWB_data),
    .EXMEM_alu_result(EXMEM_alu_result), .EXMEM_write_data(EXMEM_write_data),
    .EXMEM_rd(EXMEM_rd), .EXMEM_WriteBack(EXMEM_WriteBack),
    .EXMEM_MemoryRead(EXMEM_MemoryRead), .EXMEM_MemoryWrite(EXMEM_MemoryWrite),
    .ex_stall(ex_stall)
  );

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned       sh = b % 32;
    logic signed [31:0] sa = a;
    longint unsigned   pa = a, pb = b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return sa >>> sh;
      8:  return a | b;
      9:  return a & b;
      10: return 32'(pa * pb);
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] div_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [31:0] q, r;
    if (op == 13 || op == 15) begin
      q = (b == 0) ? 32'hFFFF_FFFF : a / b;
      r = (b == 0) ? a : a % b;
    end else if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
    return (op >= 14) ? r : q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_exmem(input string tag, input logic [31:0] res, input logic [31:0] wd,
                             input logic [4:0] rd, input logic wb, input logic mr, input logic mw);
    check({tag, ".res"}, EXMEM_alu_result, res);
    check({tag, ".wd"}, EXMEM_write_data, wd);
    check({tag, ".ctl"}, {24'b0, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite},
          {24'b0, rd, wb, mr, mw});
  endtask

  task automatic set_instr(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] imm, input logic src,
                           input logic wb, input logic mr, input logic mw);
    IDEX_valid = v; IDEX_aluOP = op; IDEX_rs1 = rs1; IDEX_rs2 = rs2; IDEX_rd = rd;
    IDEX_read_data1 = d1; IDEX_read_data2 = d2; IDEX_imm = imm; IDEX_AluSrc = src;
    IDEX_WriteBack = wb; IDEX_MemoryRead = mr; IDEX_MemoryWrite = mw;
  endtask

  task automatic set_memwb(input logic [4:0] rd, input logic wb, input logic [31:0] data);
    MEMWB_rd = rd; MEMWB_WriteBack = wb; MEMWB_data = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide, counts stall cycles (bounded), then checks the result.
  task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp = div_ref(int'(op), a, b);
    int          stall_n = 0;
    logic        bub_ok = 1'b1;
    set_memwb(5'd0, 1'b0, 32'h0);
    set_instr(1'b1, op, 5'd11, 5'd12, 5'd10, a, b, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!ex_stall) break;
      stall_n++;
      step();
      if (EXMEM_WriteBack || EXMEM_MemoryRead || EXMEM_MemoryWrite) bub_ok = 1'b0;
      set_memwb(5'd11, 1'b1, $urandom);
      IDEX_read_data1 = $urandom;
    end
    check({tag, ".stall"}, 32'(stall_n), 32'd33);
    check({tag, ".bubble"}, {31'b0, bub_ok}, 32'd1);
    step();
    check({tag, ".res"}, EXMEM_alu_result, exp);
    check({tag, ".ctl"}, {24'b0, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite},
          {24'b0, 5'd10, 3'b100});
  endtask

  logic [3:0]  dv_op [6] = '{4'd12, 4'd14, 4'd13, 4'd14, 4'd12, 4'd14};
  logic [31:0] dv_a  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dv_b  [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic        p_wb, flag;
    logic [4:0]  p_rd;
    logic [31:0] p_res;

    reset = 1'b1;
    set_instr(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_memwb(5'd0, 1'b0, 32'h0);
    step(); step();
    check_exmem("reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("reset.stall", {31'b0, ex_stall}, 32'd0);
    reset = 1'b0;

    // EX/MEM holds x5=10, MEM/WB holds x5=20: EX/MEM must win.
    set_instr(1'b1, 4'd0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_exmem("ld10", 32'd10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    set_memwb(5'd5, 1'b1, 32'd20);
    set_instr(1'b1, 4'd0, 5'd5, 5'd6, 5'd7, 32'd777, 32'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_exmem("exmem_prio", 32'd13, 32'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    set_instr(1'b1, 4'd0, 5'd5, 5'd6, 5'd8, 32'd777, 32'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_exmem("memwb_fwd", 32'd23, 32'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    set_memwb(5'd0, 1'b0, 32'h0);
    set_instr(1'b1, 4'd1, 5'd9, 5'd8, 5'd9, 32'd100, 32'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_exmem("rs2_fwd", 32'd77, 32'd23, 5'd9, 1'b1, 1'b0, 1'b1);

    // Producer targets x0 with 99; consumer of x0 must see 0.
    set_instr(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'd99, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_memwb(5'd0, 1'b1, 32'd55);
    set_instr(1'b1, 4'd0, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_exmem("x0", 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);

    set_instr(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 check("bubble.stall", {31'b0, ex_stall}, 32'd0);
    step();
    check_exmem("bubble", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Random single-cycle traffic with a forwarding model of the pipeline.
    p_wb = 1'b0; p_rd = 5'd0; p_res = 32'h0;
    for (int i = 0; i < 60; i++) begin
      int          op = $urandom_range(0, 11);
      logic        v = ($urandom_range(0, 7) != 0);
      logic [4:0]  rs1 = 5'($urandom_range(0, 7)), rs2 = 5'($urandom_range(0, 7));
      logic [4:0]  rd = 5'($urandom_range(0, 7)), mrd = 5'($urandom_range(0, 7));
      logic [31:0] d1 = $urandom, d2 = $urandom, imm = $urandom, md = $urandom;
      logic        src = 1'($urandom_range(0, 1)), mwb = 1'($urandom_range(0, 1));
      logic        wb = 1'($urandom_range(0, 1)), mr = 1'($urandom_range(0, 1));
      logic        mw = 1'($urandom_range(0, 1));
      logic [31:0] a, b2, res;
      a  = (rs1 != 0 && p_wb && p_rd == rs1) ? p_res : (rs1 != 0 && mwb && mrd == rs1) ? md : d1;
      b2 = (rs2 != 0 && p_wb && p_rd == rs2) ? p_res : (rs2 != 0 && mwb && mrd == rs2) ? md : d2;
      res = alu_ref(op, a, src ? imm : b2);
      set_memwb(mrd, mwb, md);
      set_instr(v, 4'(op), rs1, rs2, rd, d1, d2, imm, src, wb, mr, mw);
      #1 check($sformatf("rand%0d.stall", i), {31'b0, ex_stall}, 32'd0);
      step();
      if (v) check_exmem($sformatf("rand%0d_op%0d", i, op), res, b2, rd, wb, mr, mw);
      else   check_exmem($sformatf("rand%0d_bub", i), 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      p_wb = v && wb; p_rd = v ? rd : 5'd0; p_res = v ? res : 32'h0;
    end

    // Reset in the middle of ordinary traffic.
    set_instr(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    check_exmem("reset_flow", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    set_instr(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_memwb(5'd0, 1'b0, 32'h0);
    step();

    // Directed special cases back to back, then random divides.
    for (int i = 0; i < 6; i++) run_div($sformatf("div%0d", i), dv_op[i], dv_a[i], dv_b[i]);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (i % 2 == 1) b = b >> $urandom_range(0, 31);
      run_div($sformatf("rdiv%0d", i), 4'($urandom_range(12, 15)), a, b);
    end
    set_instr(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_memwb(5'd0, 1'b0, 32'h0);
    step();

    // Reset ten cycles into a divide: no writeback may follow.
    set_instr(1'b1, 4'd12, 5'd11, 5'd12, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) step();
    reset = 1'b1;
    set_instr(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_exmem("rst_div", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_div.stall", {31'b0, ex_stall}, 32'd0);
    reset = 1'b0;
    flag = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (EXMEM_WriteBack || ex_stall) flag = 1'b0;
    end
    check("rst_div.quiet", {31'b0, flag}, 32'd1);
    set_instr(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_exmem("post_rst_add", 32'd2, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
